// File: rtl/wb_reg_file.sv
// wb_reg_file: 16x16 architectural register file at the writeback end.
// Ports: clk/rst; wr_* writeback commit; jal_* link write; lw_* load issue;
//   rd_* two combinational read ports; r15 link value; stall load-use hold.
module wb_reg_file #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int LINK_REG = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_lw,
  input  logic              jal_en,
  input  logic [DATA_W-1:0] jal_link,
  input  logic              lw_issue,
  input  logic [ADDR_W-1:0] lw_dst,
  input  logic              rd_en_a,
  input  logic              rd_en_b,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic [DATA_W-1:0] r15,
  output logic              stall
);

  localparam int N = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LINK = ADDR_W'(LINK_REG);

  logic [DATA_W-1:0] regs [N];
  logic [N-1:0]      pending;
  logic [N-1:0]      pend_nxt;
  logic              clr_a;
  logic              clr_b;
  logic              lw_set;

  // Bypass order: R0, then link port, then writeback, then storage.
  function automatic logic [DATA_W-1:0] rd_port(
    input logic [ADDR_W-1:0] a
  );
    if (a == '0)
      return '0;
    else if (jal_en && a == LINK)
      return jal_link;
    else if (wr_en && wr_addr == a)
      return wr_data;
    else
      return regs[a];
  endfunction

  assign rd_data_a = rd_port(rd_addr_a);
  assign rd_data_b = rd_port(rd_addr_b);
  assign r15       = rd_port(LINK);

  // A load completing this cycle is forwarded, so it must not stall.
  assign clr_a = wr_en & wr_lw & (wr_addr == rd_addr_a);
  assign clr_b = wr_en & wr_lw & (wr_addr == rd_addr_b);

  assign stall = (rd_en_a & pending[rd_addr_a] & ~clr_a)
               | (rd_en_b & pending[rd_addr_b] & ~clr_b);

  // Loads cannot issue while decode is held.
  assign lw_set = lw_issue & ~stall & (lw_dst != '0);

  // Set applied after clear: the newer load stays outstanding.
  always_comb begin
    pend_nxt = pending;
    if (wr_en && wr_lw)
      pend_nxt[wr_addr] = 1'b0;
    if (lw_set)
      pend_nxt[lw_dst] = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++)
        regs[i] <= '0;
      pending <= '0;
    end else begin
      for (int i = 1; i < N; i++) begin
        if (jal_en && ADDR_W'(i) == LINK)
          regs[i] <= jal_link;
        else if (wr_en && wr_addr == ADDR_W'(i))
          regs[i] <= wr_data;
      end
      pending <= pend_nxt;
    end
  end

endmodule
